// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD path: FSM states, digit constants
// and the default widths reused by the seven-segment display driver.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_e;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] ADD3_THRESH = 4'd5;
    localparam int         DEFAULT_W   = 16;
    localparam int         DEFAULT_D   = 5;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/done handshake bundle between the factorial unit and bin2bcd_seq.
// The blank vector exists only when BIN2BCD_BLANK_EN is defined.
interface bin2bcd_seq_if
    import bcd_pkg::*;
#(
    parameter int W = DEFAULT_W,
    parameter int D = DEFAULT_D
);
    logic             start;
    logic [W-1:0]     bin;
    logic             busy;
    logic             done;
    logic [4*D-1:0]   bcd;
`ifdef BIN2BCD_BLANK_EN
    logic [D-1:0]     blank;

    modport master (output start, bin, input busy, done, bcd, blank);
    modport slave  (input start, bin, output busy, done, bcd, blank);
`else
    modport master (output start, bin, input busy, done, bcd);
    modport slave  (input start, bin, output busy, done, bcd);
`endif
endinterface

// File: rtl/bcd_add3_digit.sv
// One digit of the shift-and-add-3 correction: values of 5 and above get +3
// so the following left shift carries correctly into the next digit.
module bcd_add3_digit
    import bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);
    // Conditional add-3 correction
    always_comb begin
        dout = din;
        if (din >= ADD3_THRESH) begin
            dout = din + 4'd3;
        end else begin
            dout = din;
        end
    end
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock, four-phase start/done.
// Optional leading-zero blank output when BIN2BCD_BLANK_EN is defined.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int W = DEFAULT_W,
    parameter int D = DEFAULT_D
)(
    input  logic          clk,
    input  logic          reset,
    bin2bcd_seq_if.slave  bus
);
    localparam int SW    = BCD_DIGIT_W * D;
    localparam int CNT_W = $clog2(W + 1);

    bcd_state_e        state_r, state_next_s;
    logic [W-1:0]      bin_r, bin_next_s;
    logic [SW-1:0]     scratch_r, scratch_next_s, scratch_adj_s;
    logic [CNT_W-1:0]  cnt_r, cnt_next_s;
    logic [SW-1:0]     bcd_r;
    logic              busy_r, done_r, bcd_load_s;
    logic [SW+W-1:0]   wide_s;

    for (genvar g = 0; g < D; g++) begin : g_digit
        bcd_add3_digit u_add3 (
            .din  (scratch_r[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (scratch_adj_s[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Corrected scratch and binary register shifted together as one word
    always_comb begin
        wide_s = {scratch_adj_s, bin_r} << 1;
    end

    // Next-state, datapath and completion-load decode
    always_comb begin
        state_next_s   = state_r;
        bin_next_s     = bin_r;
        scratch_next_s = scratch_r;
        cnt_next_s     = cnt_r;
        bcd_load_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    bin_next_s     = bus.bin;
                    scratch_next_s = '0;
                    cnt_next_s     = CNT_W'(W);
                    state_next_s   = SHIFT;
                end else begin
                    state_next_s   = IDLE;
                end
            end
            SHIFT: begin
                bin_next_s     = wide_s[W-1:0];
                scratch_next_s = wide_s[SW+W-1:W];
                cnt_next_s     = cnt_r - CNT_W'(1);
                if (cnt_r == CNT_W'(1)) begin
                    state_next_s = DONE;
                    bcd_load_s   = 1'b1;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            bin_r     <= '0;
            scratch_r <= '0;
            cnt_r     <= '0;
            bcd_r     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            bin_r     <= bin_next_s;
            scratch_r <= scratch_next_s;
            cnt_r     <= cnt_next_s;
            busy_r    <= (state_next_s == SHIFT);
            done_r    <= (state_next_s == DONE);
            if (bcd_load_s) begin
                bcd_r <= wide_s[SW+W-1:W];
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.bcd  = bcd_r;

`ifdef BIN2BCD_BLANK_EN
    localparam logic [D-1:0] BLANK_RST = {{(D-1){1'b1}}, 1'b0};

    logic [D-1:0] blank_s, blank_r;
    logic         zero_run_s;

    // Blank runs of zero digits from the MSB down; digit 0 always shows
    always_comb begin
        blank_s    = '0;
        zero_run_s = 1'b1;
        for (int i = D - 1; i >= 0; i--) begin
            if (wide_s[W + i*BCD_DIGIT_W +: BCD_DIGIT_W] != 4'd0) begin
                zero_run_s = 1'b0;
            end else begin
                zero_run_s = zero_run_s;
            end
            blank_s[i] = zero_run_s;
        end
        blank_s[0] = 1'b0;
    end

    // Blank mask register, loaded together with bcd
    always_ff @(posedge clk) begin
        if (reset) begin
            blank_r <= BLANK_RST;
        end else if (bcd_load_s) begin
            blank_r <= blank_s;
        end else begin
            blank_r <= blank_r;
        end
    end

    assign bus.blank = blank_r;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed, table-driven bench for bin2bcd_seq: latency, hold, ignore-during-
// conversion, mid-conversion reset and (when enabled) the blank mask.
module tb_bin2bcd_seq;
    import bcd_pkg::*;

    typedef struct {
        logic [15:0] bin;
        logic [19:0] exp_bcd;
        logic [4:0]  exp_blank;
    } vec_t;

    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;

    bin2bcd_seq_if #(.W(16), .D(5)) bus ();

    bin2bcd_seq #(.W(16), .D(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept bin, wait for done, check latency, busy span, result and hold after start drops
    task automatic convert(input logic [15:0] b, input logic [19:0] eb, input logic [4:0] ebl);
        int n;
        int busy_n;
        n      = 0;
        busy_n = 0;
        bus.bin   = b;
        bus.start = 1'b1;
        step();
        if (bus.busy === 1'b1) busy_n++;
        for (int k = 0; k < 40; k++) begin
            step();
            n++;
            if (bus.done === 1'b1) break;
            if (bus.busy === 1'b1) busy_n++;
        end
        check("latency", n, 16);
        check("busy_cycles", busy_n, 16);
        check("busy_at_done", {31'd0, bus.busy}, 32'd0);
        check("bcd", {12'd0, bus.bcd}, {12'd0, eb});
`ifdef BIN2BCD_BLANK_EN
        check("blank", {27'd0, bus.blank}, {27'd0, ebl});
`else
        if (ebl === 5'bxxxxx) $display("unexpected blank");
`endif
        bus.start = 1'b0;
        step();
        check("done_drop", {31'd0, bus.done}, 32'd0);
        check("bcd_hold", {12'd0, bus.bcd}, {12'd0, eb});
    endtask

    initial begin
        vec_t vecs [6];
        n_total   = 0;
        n_pass    = 0;
        vecs[0] = '{16'd0,     20'h00000, 5'b11110};
        vecs[1] = '{16'd720,   20'h00720, 5'b11000};
        vecs[2] = '{16'd5040,  20'h05040, 5'b10000};
        vecs[3] = '{16'd65535, 20'h65535, 5'b00000};
        vecs[4] = '{16'd24,    20'h00024, 5'b11100};
        vecs[5] = '{16'd9999,  20'h09999, 5'b10000};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.bin   = 16'd0;
        step();
        step();
        reset = 1'b0;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_bcd", {12'd0, bus.bcd}, 32'd0);
`ifdef BIN2BCD_BLANK_EN
        check("rst_blank", {27'd0, bus.blank}, {27'd0, 5'b11110});
`endif
        step();

        for (int i = 0; i < 6; i++) begin
            convert(vecs[i].bin, vecs[i].exp_bcd, vecs[i].exp_blank);
        end

        // start held after done: no second conversion
        bus.bin   = 16'd1234;
        bus.start = 1'b1;
        step();
        for (int k = 0; k < 16; k++) step();
        check("held_done", {31'd0, bus.done}, 32'd1);
        bus.bin = 16'd77;
        for (int k = 0; k < 20; k++) begin
            step();
            check("held_no_busy", {30'd0, bus.busy, bus.done}, 32'd1);
        end
        check("held_bcd", {12'd0, bus.bcd}, {12'd0, 20'h01234});
        bus.start = 1'b0;
        step();
        check("held_drop", {30'd0, bus.busy, bus.done}, 32'd0);
        check("held_bcd_kept", {12'd0, bus.bcd}, {12'd0, 20'h01234});

        // bin and start disturbed during conversion are ignored
        bus.bin   = 16'd24;
        bus.start = 1'b1;
        step();
        bus.bin = 16'd999;
        for (int k = 1; k < 16; k++) begin
            bus.start = (k > 10) ? 1'b1 : k[0];
            step();
            check("dist_busy", {30'd0, bus.busy, bus.done}, 32'd2);
        end
        step();
        check("dist_done", {30'd0, bus.busy, bus.done}, 32'd1);
        check("dist_bcd", {12'd0, bus.bcd}, {12'd0, 20'h00024});
        bus.start = 1'b0;
        step();

        // reset partway through SHIFT discards the result
        bus.bin   = 16'd999;
        bus.start = 1'b1;
        step();
        for (int k = 0; k < 8; k++) step();
        check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        step();
        reset     = 1'b0;
        bus.start = 1'b0;
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_done", {31'd0, bus.done}, 32'd0);
        check("mid_rst_bcd", {12'd0, bus.bcd}, 32'd0);
        step();
        check("post_rst_idle", {30'd0, bus.busy, bus.done}, 32'd0);
        convert(16'd40320, 20'h40320, 5'b00000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
